conv_2d_feeder: RTL and testbench
=================================

# conv_2d_feeder

Upstream stage of `conv_2d`. Captures a 3x3 kernel from a serial coefficient stream and replays it as three column-loads. Then turns a raster-order stream of padded-frame pixels into the one-column-per-cycle, three-row window stream that `conv_2d` consumes on `i_data1/2/3` with `i_load_knl`/`i_en_conv`. Two internal line buffers hold the previous two rows, so the source sends each pixel exactly once.

## Interface
Parameters:
- `DATA_WIDTH`, 8: pixel/coefficient width (signed two's complement).
- `IMAGE_WIDTH`, 12: padded frame width in pixels; must be ≥ 3.
- `IMAGE_HEIGHT`, 3: padded frame height in rows; must be ≥ 3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_knl_valid`  in  1  kernel coefficient present on `i_knl`.
- `i_knl`  in  DATA_WIDTH  coefficient, row-major order k1..k9.
- `i_px_valid`  in  1  pixel present on `i_pixel`.
- `i_pixel`  in  DATA_WIDTH  padded-frame pixel, raster order (row 0 col 0 first).
- `o_ready`  out  1  current input is accepted this cycle (see Operation).
- `o_load_knl`  out  1  drives `conv_2d.i_load_knl`.
- `o_en_conv`  out  1  drives `conv_2d.i_en_conv`; high = column on data outputs is valid.
- `o_data1`, `o_data2`, `o_data3`  out  DATA_WIDTH each  column: top, middle, bottom row.
- `o_frame_done`  out  1  one-cycle pulse with the last column of a frame.

## Operation
- States: KNL_CAP, KNL_LOAD, FILL, STREAM.
- KNL_CAP: `o_ready` = 1. Each `i_knl_valid` stores `i_knl` into slot `knl_cnt` (0..8). Pixels are ignored. After slot 8, go to KNL_LOAD.
- KNL_LOAD: 3 cycles with `o_load_knl` = 1. Outputs are (k1,k4,k7), then (k2,k5,k8), then (k3,k6,k9). `o_ready` = 0. Then go to FILL with row = col = 0.
- FILL (rows 0 and 1):
  - `o_ready` = 1.
  - Each accepted pixel writes the line buffer at `col` and does not raise `o_en_conv`.
  - If `i_knl_valid` is high while row = col = 0, it takes priority over the pixel: store the coefficient as slot 0, set `knl_cnt` to 1 and go to KNL_CAP. A new kernel can only start at a frame boundary.
  - `i_knl_valid` at any other position is ignored.
- STREAM (rows 2..IMAGE_HEIGHT-1): for each accepted pixel p at column j, the next cycle registers:
  - `o_data1` = lb_top[j], `o_data2` = lb_mid[j], `o_data3` = p, `o_en_conv` = 1.
  - lb_top[j] ← lb_mid[j] and lb_mid[j] ← p on the same edge.
- Line-buffer write rule in FILL: row 0 writes lb_mid; row 1 shifts lb_mid into lb_top and writes lb_mid.
- Counters: `col` wraps IMAGE_WIDTH-1 → 0 and increments `row`. At row = IMAGE_HEIGHT-1 and col = IMAGE_WIDTH-1, assert `o_frame_done` with that column and return to FILL with row = col = 0. The kernel is retained.
- Stall: when `i_px_valid` = 0, counters and buffers hold, `o_en_conv` = 0 and the data outputs hold their last value.
- `o_ready` = 0 only in KNL_LOAD. Inputs presented then are dropped, and the source must hold them.
- Reset values: state KNL_CAP, all counters 0, all outputs 0, kernel slots 0. Line-buffer contents need not be reset.
- Reset asserted mid-frame or mid-load: immediate return to the reset values. The next frame must start with a full kernel.

## Timing
- Pixel-to-column latency: 1 cycle (registered outputs). Throughput: 1 column per cycle.
- Kernel: the `o_load_knl` window starts the cycle after the 9th coefficient is accepted. The first pixel is accepted no earlier than the cycle after the window ends.
- Per frame: (IMAGE_HEIGHT-2)·IMAGE_WIDTH columns with `o_en_conv` = 1.
- No combinational path from inputs to outputs. `o_ready` depends on state only.

## Structure
- Shared package `conv_pkg`: `DATA_WIDTH`, `KNL_TAPS` = 9, `KNL_COLS` = 3, state enum encoding. `conv_2d` also uses this package.
- Sub-module `line_buffer_2row`: two IMAGE_WIDTH×DATA_WIDTH register arrays. It has an indexed read of both rows at `col` plus a shift-write. The FSM and kernel store stay in the top module.

## Test plan
- Identity kernel k5 = 1, others 0 → `o_load_knl` high 3 cycles with columns (0,0,0), (0,1,0), (0,0,0).
- 3×12 frame with pixel = row·16+col, continuous valid → 12 columns, column j = (j, 16+j, 32+j). `o_frame_done` on j = 11.
- Same frame with `i_px_valid` low for 2 cycles at row 2 col 5 → outputs hold (4,20,36) with `o_en_conv` = 0, then the column sequence resumes unchanged.
- 5×4 frame → 12 valid columns. Row 4 col 1 = (pixels of rows 2,3,4 at col 1).
- `i_knl_valid` mid-frame ignored. At a frame boundary, 9 new coefficients trigger a new load window before the next frame.
- `i_nrst` low at row 2 col 3 → all outputs 0 next cycle. After release, pixels are ignored until 9 coefficients are loaded.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the conv_2d datapath and its feeder.
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int KNL_TAPS   = 9;
  localparam int KNL_COLS   = 3;

  typedef enum logic [1:0] {
    KNL_CAP  = 2'd0,
    KNL_LOAD = 2'd1,
    FILL     = 2'd2,
    STREAM   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/line_buffer_2row.sv
// Two-row pixel history for the feeder: indexed read of both rows at one
// column, with an optional top<-mid shift and a mid write at that column.
module line_buffer_2row #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_WIDTH = 12
) (
  input  logic                           clk,
  input  logic [$clog2(IMAGE_WIDTH)-1:0] i_col,
  input  logic                           i_wr_mid,
  input  logic                           i_shift_top,
  input  logic [DATA_WIDTH-1:0]          i_px,
  output logic [DATA_WIDTH-1:0]          o_top,
  output logic [DATA_WIDTH-1:0]          o_mid
);

  logic [DATA_WIDTH-1:0] top_q [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] top_d [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] mid_q [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] mid_d [IMAGE_WIDTH];

  assign o_top = top_q[i_col];
  assign o_mid = mid_q[i_col];

  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    if (i_shift_top) top_d[i_col] = mid_q[i_col];
    if (i_wr_mid)    mid_d[i_col] = i_px;
  end

  // Contents are don't-care until rows 0/1 of a frame have been written.
  always_ff @(posedge clk) begin
    top_q <= top_d;
    mid_q <= mid_d;
  end

endmodule

// File: rtl/conv_2d_feeder.sv
// Kernel capture/replay and 3-row window generation in front of conv_2d.
//   state    | meaning
//   KNL_CAP  | accept 9 serial coefficients, pixels ignored
//   KNL_LOAD | replay kernel as 3 column-loads, inputs not accepted
//   FILL     | rows 0..1, pixels only fill the line buffers
//   STREAM   | rows 2..H-1, one window column out per accepted pixel
module conv_2d_feeder #(
  parameter int DATA_WIDTH   = conv_pkg::DATA_WIDTH,
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  i_nrst,
  input  logic                  i_knl_valid,
  input  logic [DATA_WIDTH-1:0] i_knl,
  input  logic                  i_px_valid,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic                  o_ready,
  output logic                  o_load_knl,
  output logic                  o_en_conv,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic [DATA_WIDTH-1:0] o_data3,
  output logic                  o_frame_done
);
  import conv_pkg::*;

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  feeder_state_e         state_q, state_d;
  logic [3:0]            knl_cnt_q, knl_cnt_d;
  logic [1:0]            ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] knl_q [KNL_TAPS];
  logic [DATA_WIDTH-1:0] knl_d [KNL_TAPS];
  logic                  load_knl_q, load_knl_d;
  logic                  en_conv_q, en_conv_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;

  logic                  lb_wr_mid, lb_shift_top;
  logic [DATA_WIDTH-1:0] lb_top, lb_mid;
  logic [3:0]            tap;
  logic                  at_last_col, at_last_px;

  line_buffer_2row #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMAGE_WIDTH(IMAGE_WIDTH)
  ) u_lb (
    .clk        (clk),
    .i_col      (col_q),
    .i_wr_mid   (lb_wr_mid),
    .i_shift_top(lb_shift_top),
    .i_px       (i_pixel),
    .o_top      (lb_top),
    .o_mid      (lb_mid)
  );

  assign tap         = {2'b00, ld_cnt_q};
  assign at_last_col = (col_q == COL_LAST);
  assign at_last_px  = at_last_col && (row_q == ROW_LAST);

  always_comb begin
    state_d      = state_q;
    knl_cnt_d    = knl_cnt_q;
    ld_cnt_d     = ld_cnt_q;
    col_d        = col_q;
    row_d        = row_q;
    knl_d        = knl_q;
    load_knl_d   = 1'b0;
    en_conv_d    = 1'b0;
    frame_done_d = 1'b0;
    data1_d      = data1_q;
    data2_d      = data2_q;
    data3_d      = data3_q;
    lb_wr_mid    = 1'b0;
    lb_shift_top = 1'b0;
    case (state_q)
      KNL_CAP: begin
        if (i_knl_valid) begin
          knl_d[knl_cnt_q] = i_knl;
          if (knl_cnt_q == 4'(KNL_TAPS - 1)) begin
            // First column needs only k1/k4/k7, already stored, so the
            // load window opens on the very next cycle.
            knl_cnt_d  = 4'd0;
            ld_cnt_d   = 2'd1;
            load_knl_d = 1'b1;
            data1_d    = knl_q[0];
            data2_d    = knl_q[KNL_COLS];
            data3_d    = knl_q[2*KNL_COLS];
            state_d    = KNL_LOAD;
          end else begin
            knl_cnt_d = knl_cnt_q + 4'd1;
          end
        end
      end
      KNL_LOAD: begin
        if (ld_cnt_q == 2'(KNL_COLS)) begin
          ld_cnt_d = 2'd0;
          col_d    = '0;
          row_d    = '0;
          state_d  = FILL;
        end else begin
          load_knl_d = 1'b1;
          ld_cnt_d   = ld_cnt_q + 2'd1;
          data1_d    = knl_q[tap];
          data2_d    = knl_q[tap + 4'd3];
          data3_d    = knl_q[tap + 4'd6];
        end
      end
      FILL: begin
        if (i_knl_valid && (row_q == '0) && (col_q == '0)) begin
          knl_d[0]  = i_knl;
          knl_cnt_d = 4'd1;
          state_d   = KNL_CAP;
        end else if (i_px_valid) begin
          lb_wr_mid    = 1'b1;
          lb_shift_top = (row_q != '0);
          if (at_last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (row_q == RW'(1)) state_d = STREAM;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (i_px_valid) begin
          en_conv_d    = 1'b1;
          data1_d      = lb_top;
          data2_d      = lb_mid;
          data3_d      = i_pixel;
          lb_wr_mid    = 1'b1;
          lb_shift_top = 1'b1;
          if (at_last_px) begin
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
            state_d      = FILL;
          end else if (at_last_col) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = KNL_CAP;
    endcase
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= KNL_CAP;
      knl_cnt_q    <= '0;
      ld_cnt_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      for (int i = 0; i < KNL_TAPS; i++) knl_q[i] <= '0;
      load_knl_q   <= 1'b0;
      en_conv_q    <= 1'b0;
      frame_done_q <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
      data3_q      <= '0;
    end else begin
      state_q      <= state_d;
      knl_cnt_q    <= knl_cnt_d;
      ld_cnt_q     <= ld_cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      knl_q        <= knl_d;
      load_knl_q   <= load_knl_d;
      en_conv_q    <= en_conv_d;
      frame_done_q <= frame_done_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data3_q      <= data3_d;
    end
  end

  assign o_ready      = (state_q != KNL_LOAD);
  assign o_load_knl   = load_knl_q;
  assign o_en_conv    = en_conv_q;
  assign o_frame_done = frame_done_q;
  assign o_data1      = data1_q;
  assign o_data2      = data2_q;
  assign o_data3      = data3_q;

endmodule

// File: tb/tb_conv_2d_feeder.sv
// Scoreboard bench for conv_2d_feeder: a 12x3 instance and a 4x5 instance
// sharing one stimulus stream.
module tb_conv_2d_feeder;

  logic       clk = 1'b0;
  logic       i_nrst;
  logic       i_knl_valid, i_px_valid;
  logic [7:0] i_knl, i_pixel;

  logic       a_ready, a_load, a_en, a_done;
  logic [7:0] a_d1, a_d2, a_d3;
  logic       b_ready, b_load, b_en, b_done;
  logic [7:0] b_d1, b_d2, b_d3;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic       done;
  } col_t;

  col_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  conv_2d_feeder #(.DATA_WIDTH(8), .IMAGE_WIDTH(12), .IMAGE_HEIGHT(3)) dut_a (
    .clk(clk), .i_nrst(i_nrst), .i_knl_valid(i_knl_valid), .i_knl(i_knl),
    .i_px_valid(i_px_valid), .i_pixel(i_pixel), .o_ready(a_ready),
    .o_load_knl(a_load), .o_en_conv(a_en), .o_data1(a_d1), .o_data2(a_d2),
    .o_data3(a_d3), .o_frame_done(a_done)
  );

  conv_2d_feeder #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(5)) dut_b (
    .clk(clk), .i_nrst(i_nrst), .i_knl_valid(i_knl_valid), .i_knl(i_knl),
    .i_px_valid(i_px_valid), .i_pixel(i_pixel), .o_ready(b_ready),
    .o_load_knl(b_load), .o_en_conv(b_en), .o_data1(b_d1), .o_data2(b_d2),
    .o_data3(b_d3), .o_frame_done(b_done)
  );

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  task automatic apply_reset();
    i_nrst = 1'b0; i_knl_valid = 1'b0; i_px_valid = 1'b0;
    @(negedge clk);
    i_nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_nrst = 1'b0; i_knl_valid = 1'b0; i_px_valid = 1'b0; i_knl = '0; i_pixel = '0;
    #12;
    n_cmp++;
    if ({a_load, a_en, a_d1, a_d2, a_d3, a_done, a_ready} !== {28'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_a: got load=%b en=%b d=%h,%h,%h done=%b ready=%b, want 0 0 0,0,0 0 1",
               a_load, a_en, a_d1, a_d2, a_d3, a_done, a_ready);
    end
    n_cmp++;
    if ({b_load, b_en, b_d1, b_d2, b_d3, b_done, b_ready} !== {28'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_b: got load=%b en=%b d=%h,%h,%h done=%b ready=%b, want 0 0 0,0,0 0 1",
               b_load, b_en, b_d1, b_d2, b_d3, b_done, b_ready);
    end
    @(negedge clk);
    i_nrst = 1'b1;
    i_px_valid = 1'b1; i_pixel = 8'h33;
    @(posedge clk); #1;
    i_px_valid = 1'b0;
    n_cmp++;
    if (a_en !== 1'b0 || a_load !== 1'b0 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_px_ignored: got en=%b load=%b ready=%b, want 0 0 1", a_en, a_load, a_ready);
    end
  endtask

  task automatic test_kernel_load(input logic [71:0] kv, input bit with_px);
    col_t e;
    int   seen;
    sb.delete();
    for (int i = 0; i < 9; i++) begin
      i_knl_valid = 1'b1; i_knl = kv[i*8 +: 8];
      i_px_valid = with_px; i_pixel = 8'h5A;
      @(posedge clk); #1;
      if (i < 8) begin
        n_cmp++;
        if (a_load !== 1'b0 || a_en !== 1'b0 || a_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL knl_capture slot %0d: got load=%b en=%b ready=%b, want 0 0 1",
                   i, a_load, a_en, a_ready);
        end
      end
    end
    i_knl_valid = 1'b0; i_px_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      e.d1 = kv[c*8 +: 8]; e.d2 = kv[(c+3)*8 +: 8]; e.d3 = kv[(c+6)*8 +: 8]; e.done = 1'b0;
      sb.push_back(e);
    end
    n_cmp++;
    if (a_load !== 1'b1) begin
      n_bad++;
      $display("FAIL knl_window_start: got load=%b, want 1", a_load);
    end
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (a_load === 1'b1) begin
        seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL knl_extra_column: got %h,%h,%h, want no column", a_d1, a_d2, a_d3);
        end else begin
          e = sb.pop_front();
          if (a_d1 !== e.d1 || a_d2 !== e.d2 || a_d3 !== e.d3 || a_ready !== 1'b0 || a_en !== 1'b0) begin
            n_bad++;
            $display("FAIL knl_column %0d: got %h,%h,%h ready=%b en=%b, want %h,%h,%h ready=0 en=0",
                     cyc, a_d1, a_d2, a_d3, a_ready, a_en, e.d1, e.d2, e.d3);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 3 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL knl_window_len: got %0d columns, want 3", seen);
    end
    n_cmp++;
    if (a_load !== 1'b0 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL knl_after: got load=%b ready=%b, want 0 1", a_load, a_ready);
    end
  endtask

  task automatic test_frame(input int stall_col, input bit mid_knl);
    col_t e, last;
    int   ncols;
    sb.delete(); ncols = 0; last = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 12; c++) begin
        if (r == 2 && c == stall_col) begin
          for (int s = 0; s < 2; s++) begin
            i_px_valid = 1'b0; i_knl_valid = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (a_en !== 1'b0 || a_d1 !== last.d1 || a_d2 !== last.d2 || a_d3 !== last.d3) begin
              n_bad++;
              $display("FAIL stall_hold: got en=%b %h,%h,%h, want en=0 %h,%h,%h",
                       a_en, a_d1, a_d2, a_d3, last.d1, last.d2, last.d3);
            end
          end
        end
        i_px_valid = 1'b1; i_pixel = pix(r, c);
        i_knl_valid = mid_knl && ((r == 1 && c == 3) || (r == 2 && c == 7));
        i_knl = 8'h7F;
        if (r >= 2) begin
          e.d1 = pix(r-2, c); e.d2 = pix(r-1, c); e.d3 = pix(r, c); e.done = (c == 11);
          sb.push_back(e);
        end
        @(posedge clk); #1;
        if (a_load !== 1'b0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_no_load r%0d c%0d: got load=1, want 0", r, c);
        end
        if (a_en === 1'b1) begin
          ncols++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL frame_extra_column r%0d c%0d: got %h,%h,%h, want none", r, c, a_d1, a_d2, a_d3);
          end else begin
            e = sb.pop_front();
            last = e;
            if (a_d1 !== e.d1 || a_d2 !== e.d2 || a_d3 !== e.d3 || a_done !== e.done) begin
              n_bad++;
              $display("FAIL frame_column c%0d: got %h,%h,%h done=%b, want %h,%h,%h done=%b",
                       c, a_d1, a_d2, a_d3, a_done, e.d1, e.d2, e.d3, e.done);
            end
          end
        end else if (a_done !== 1'b0) begin
          n_cmp++; n_bad++;
          $display("FAIL frame_done_stray r%0d c%0d: got done=1, want 0", r, c);
        end
      end
    end
    i_px_valid = 1'b0; i_knl_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ncols != 12 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL frame_count: got %0d columns, want 12", ncols);
    end
    n_cmp++;
    if (a_en !== 1'b0 || a_done !== 1'b0 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_idle: got en=%b done=%b ready=%b, want 0 0 1", a_en, a_done, a_ready);
    end
  endtask

  task automatic test_5x4();
    col_t e;
    int   ncols;
    sb.delete(); ncols = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        i_px_valid = 1'b1; i_pixel = pix(r, c);
        if (r >= 2) begin
          e.d1 = pix(r-2, c); e.d2 = pix(r-1, c); e.d3 = pix(r, c); e.done = (r == 4 && c == 3);
          sb.push_back(e);
        end
        @(posedge clk); #1;
        if (b_en === 1'b1) begin
          ncols++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL b_extra_column r%0d c%0d: got %h,%h,%h, want none", r, c, b_d1, b_d2, b_d3);
          end else begin
            e = sb.pop_front();
            if (b_d1 !== e.d1 || b_d2 !== e.d2 || b_d3 !== e.d3 || b_done !== e.done || b_load !== 1'b0) begin
              n_bad++;
              $display("FAIL b_column r%0d c%0d: got %h,%h,%h done=%b, want %h,%h,%h done=%b",
                       r, c, b_d1, b_d2, b_d3, b_done, e.d1, e.d2, e.d3, e.done);
            end
          end
          if (r == 4 && c == 1) begin
            n_cmp++;
            if ({b_d1, b_d2, b_d3} !== {8'd33, 8'd49, 8'd65}) begin
              n_bad++;
              $display("FAIL b_row4_col1: got %0d,%0d,%0d, want 33,49,65", b_d1, b_d2, b_d3);
            end
          end
        end
      end
    end
    i_px_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ncols != 12 || sb.size() != 0 || b_en !== 1'b0) begin
      n_bad++;
      $display("FAIL b_count: got %0d columns (en=%b), want 12 then 0", ncols, b_en);
    end
  endtask

  task automatic test_reset_mid(input logic [71:0] kv);
    for (int n = 0; n < 27; n++) begin
      i_px_valid = 1'b1; i_pixel = pix(n / 12, n % 12);
      @(posedge clk); #1;
    end
    i_px_valid = 1'b0;
    n_cmp++;
    if (a_en !== 1'b1 || a_d3 !== pix(2, 2)) begin
      n_bad++;
      $display("FAIL mid_pre_reset: got en=%b d3=%h, want 1 %h", a_en, a_d3, pix(2, 2));
    end
    i_nrst = 1'b0;
    #2;
    n_cmp++;
    if ({a_load, a_en, a_d1, a_d2, a_d3, a_done, a_ready} !== {28'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset_out: got load=%b en=%b d=%h,%h,%h done=%b ready=%b, want 0 0 0,0,0 0 1",
               a_load, a_en, a_d1, a_d2, a_d3, a_done, a_ready);
    end
    @(negedge clk);
    i_nrst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) begin
      i_px_valid = 1'b1; i_pixel = pix(0, n);
      @(posedge clk); #1;
      n_cmp++;
      if (a_en !== 1'b0 || a_load !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_px_ignored %0d: got en=%b load=%b, want 0 0", n, a_en, a_load);
      end
    end
    i_px_valid = 1'b0;
    test_kernel_load(kv, 1'b1);
    test_frame(-1, 1'b0);
  endtask

  initial begin
    logic [71:0] k_id, k_new;
    k_id = '0;
    k_id[4*8 +: 8] = 8'd1;
    for (int i = 0; i < 9; i++) k_new[i*8 +: 8] = 8'(i + 1);
    k_new[5*8 +: 8] = 8'hFD;

    test_reset();
    test_kernel_load(k_id, 1'b1);
    test_frame(-1, 1'b0);
    test_frame(5, 1'b0);
    test_frame(-1, 1'b1);
    test_kernel_load(k_new, 1'b1);
    test_frame(-1, 1'b0);
    apply_reset();
    test_kernel_load(k_new, 1'b0);
    test_5x4();
    apply_reset();
    test_kernel_load(k_id, 1'b0);
    test_reset_mid(k_new);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
